// File: rtl/usb_fifo_pkg.sv
// Shared constants and helpers for the USB stream FIFO.
package usb_fifo_pkg;

  localparam int unsigned USB_DATA_W = 16;
  localparam int unsigned CNT_W      = 32;

  // Level must hold 0..DEPTH inclusive, hence one bit wider than the address.
  function automatic int unsigned level_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/usb_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset (BRAM inference).
module usb_fifo_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output holds its value while re is low, so a fetched word can wait for the prefetch slot.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/usb_stream_fifo.sv
// BRAM-backed FWFT stream FIFO between the EZ-USB slave FIFO and user logic.
// Optional word counters are built when USB_FIFO_STATS_EN is defined.
module usb_stream_fifo
  import usb_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = USB_DATA_W,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                        ifclk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [level_w(ADDR_W)-1:0]  level,
  output logic                        almost_full,
  output logic                        empty,
  output logic [CNT_W-1:0]            in_count,
  output logic [CNT_W-1:0]            out_count
);

  localparam int unsigned LVL_W = level_w(ADDR_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic              reset_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              q_valid;
  logic [DATA_W-1:0] ram_rdata;

  logic              wr_en_c;
  logic              rd_en_c;
  logic              q_load_c;
  logic              ram_re_c;
  logic              ram_we_c;
  logic [LVL_W-1:0]  ram_cnt_c;
  logic [LVL_W-1:0]  level_nxt_c;

  assign in_ready = !reset_q && (level < LVL_W'(DEPTH));
  assign empty    = (level == '0);

  // q_valid marks a word fetched from RAM and waiting in the RAM output register.
  always_comb begin
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    q_load_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_cnt_c   = '0;
    level_nxt_c = level;

    wr_en_c   = in_valid && in_ready;
    rd_en_c   = out_valid && out_ready;
    q_load_c  = q_valid && (!out_valid || out_ready);
    ram_cnt_c = level - LVL_W'(out_valid) - LVL_W'(q_valid);
    ram_re_c  = !reset && !flush && (ram_cnt_c != '0) && (!q_valid || q_load_c);
    ram_we_c  = !reset && !flush && wr_en_c;

    if (wr_en_c && !rd_en_c) begin
      level_nxt_c = level + LVL_W'(1);
    end else if (rd_en_c && !wr_en_c) begin
      level_nxt_c = level - LVL_W'(1);
    end
  end

  always_ff @(posedge ifclk) begin
    reset_q <= reset;
  end

  always_ff @(posedge ifclk) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_valid     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (ram_re_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      q_valid <= ram_re_c || (q_valid && !q_load_c);
      if (q_load_c) begin
        out_data  <= ram_rdata;
        out_valid <= 1'b1;
      end else if (rd_en_c) begin
        out_valid <= 1'b0;
      end
      level       <= level_nxt_c;
      almost_full <= (level_nxt_c >= LVL_W'(DEPTH - AF_MARGIN));
    end
  end

  usb_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (ifclk),
    .we    (ram_we_c),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (ram_re_c),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

`ifdef USB_FIFO_STATS_EN
  always_ff @(posedge ifclk) begin
    if (reset || flush) begin
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (wr_en_c) begin
        in_count <= in_count + CNT_W'(1);
      end
      if (rd_en_c) begin
        out_count <= out_count + CNT_W'(1);
      end
    end
  end
`else
  assign in_count  = '0;
  assign out_count = '0;
`endif

endmodule

// File: tb/tb_usb_stream_fifo.sv
// Scoreboard bench for usb_stream_fifo: words queued on accept, compared on delivery.
module tb_usb_stream_fifo;
  import usb_fifo_pkg::*;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned LVL_W     = ADDR_W + 1;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned AF_MARGIN = 4;

  logic              ifclk;
  logic              reset;
  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic              empty;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;

  int errors;
  int checks;
  int n_wr;
  int n_rd;
  logic [DATA_W-1:0] next_wr;
  logic [DATA_W-1:0] sb [$];

  usb_stream_fifo #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .ifclk       (ifclk),
    .reset       (reset),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full),
    .empty       (empty),
    .in_count    (in_count),
    .out_count   (out_count)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  // One clock: drive after the edge, observe handshakes at negedge, return 1 unit after next edge.
  task automatic cycle(input logic iv, input logic ordy);
    logic [DATA_W-1:0] exp;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = next_wr;
    @(negedge ifclk);
    if (flush) begin
      if (in_valid && in_ready) next_wr = next_wr + 1'b1;
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        n_rd++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: got %h with scoreboard empty", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL read_data: got %h expected %h", out_data, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        next_wr = next_wr + 1'b1;
        n_wr++;
      end
    end
    @(posedge ifclk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() > 0; i++) cycle(1'b0, 1'b1);
    checks++;
    if (sb.size() != 0 || level !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL drain: left=%0d level=%0d empty=%b expected 0/0/1", sb.size(), level, empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge ifclk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== '0 || empty !== 1'b1 || almost_full !== 1'b0 ||
        in_ready !== 1'b0 || out_data !== '0 || in_count !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_state: ov=%b lvl=%0d emp=%b af=%b ir=%b od=%h ic=%0d oc=%0d expected 0/0/1/0/0/0/0/0",
               out_valid, level, empty, almost_full, in_ready, out_data, in_count, out_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b expected 0", in_ready); end
    @(posedge ifclk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    next_wr = 16'h1234;
    cycle(1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || level !== LVL_W'(1)) begin
      errors++; $display("FAIL lat_n: ov=%b level=%0d expected 0/1", out_valid, level);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: ov=%b expected 0", out_valid); end
    cycle(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      errors++; $display("FAIL lat_n2: ov=%b data=%h expected 1/1234", out_valid, out_data);
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (level !== '0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_after_read: level=%0d empty=%b ov=%b expected 0/1/0", level, empty, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    next_wr = '0;
    for (int i = 0; i < 1200 && sb.size() < DEPTH; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (level !== LVL_W'(sb.size()) || almost_full !== (sb.size() >= DEPTH - AF_MARGIN) ||
          in_ready !== (sb.size() < DEPTH)) begin
        errors++;
        $display("FAIL fill_flags: level=%0d af=%b ir=%b expected level %0d", level, almost_full, in_ready, sb.size());
      end
    end
    repeat (2) cycle(1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || level !== LVL_W'(DEPTH) || almost_full !== 1'b1) begin
      errors++; $display("FAIL full_state: ir=%b level=%0d af=%b expected 0/1024/1", in_ready, level, almost_full);
    end
    for (int i = 0; i < 1200 && sb.size() > 0; i++) begin
      cycle(1'b0, 1'b1);
      if (sb.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_gap: ov=%b expected 1 at left=%0d", out_valid, sb.size()); end
      end
    end
    drain();
    checks++;
    if (almost_full !== 1'b0) begin errors++; $display("FAIL drained_af: got %b expected 0", almost_full); end
  endtask

  task automatic test_back_to_back();
    int start;
    start = n_wr;
    for (int i = 0; i < 5200 && (n_wr - start) < 5000; i++) begin
      cycle(1'b1, 1'b1);
      if (i >= 2) begin
        checks++;
        if (level !== LVL_W'(3) || out_valid !== 1'b1) begin
          errors++; $display("FAIL stream_steady: level=%0d ov=%b expected 3/1 at i=%0d", level, out_valid, i);
        end
      end
    end
    checks++;
    if (n_wr - start != 5000) begin errors++; $display("FAIL stream_count: got %0d expected 5000", n_wr - start); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      checks++;
      if (level !== LVL_W'(sb.size()) || empty !== (sb.size() == 0)) begin
        errors++; $display("FAIL random_level: level=%0d empty=%b expected %0d", level, empty, sb.size());
      end
    end
    drain();
  endtask

  task automatic test_flush();
    int rd0;
    for (int i = 0; i < 100 && sb.size() < 37; i++) cycle(1'b1, 1'b0);
    checks++;
    if (level !== LVL_W'(37)) begin errors++; $display("FAIL flush_pre_level: got %0d expected 37", level); end
    flush = 1'b1;
    cycle(1'b1, 1'b0);
    flush = 1'b0;
    checks++;
    if (level !== '0 || out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: level=%0d ov=%b empty=%b ir=%b af=%b expected 0/0/1/1/0",
               level, out_valid, empty, in_ready, almost_full);
    end
    rd0 = n_rd;
    cycle(1'b1, 1'b0);
    drain();
    checks++;
    if (n_rd - rd0 != 1) begin errors++; $display("FAIL flush_reads: got %0d expected 1", n_rd - rd0); end
  endtask

  task automatic test_stats();
    int w0;
    int r0;
    logic [CNT_W-1:0] exp_in;
    logic [CNT_W-1:0] exp_out;
    flush = 1'b1;
    cycle(1'b0, 1'b0);
    flush = 1'b0;
    w0 = n_wr;
    for (int i = 0; i < 200 && (n_wr - w0) < 100; i++) cycle(1'b1, 1'b0);
    r0 = n_rd;
    for (int i = 0; i < 200 && (n_rd - r0) < 60; i++) cycle(1'b0, 1'b1);
`ifdef USB_FIFO_STATS_EN
    exp_in  = CNT_W'(100);
    exp_out = CNT_W'(60);
`else
    exp_in  = '0;
    exp_out = '0;
`endif
    checks++;
    if (in_count !== exp_in || out_count !== exp_out || level !== LVL_W'(40)) begin
      errors++;
      $display("FAIL stats_counts: in=%0d out=%0d level=%0d expected %0d/%0d/40", in_count, out_count, level, exp_in, exp_out);
    end
    flush = 1'b1;
    cycle(1'b0, 1'b0);
    flush = 1'b0;
    checks++;
    if (in_count !== '0 || out_count !== '0 || level !== '0) begin
      errors++; $display("FAIL stats_flush: in=%0d out=%0d level=%0d expected 0/0/0", in_count, out_count, level);
    end
  endtask

  initial begin
    errors = 0; checks = 0; n_wr = 0; n_rd = 0; next_wr = '0;
    test_reset();
    test_latency();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_flush();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
